// File: rtl/wired_fetch_queue_pkg.sv
// Shared frontend types for the fetch queue and its neighbours.
package wired_fetch_queue_pkg;

  localparam int unsigned DefTidW = 1;

  typedef logic [DefTidW-1:0] epoch_t;

  typedef struct packed {
    logic   flush;
    epoch_t tid;
  } pipeline_ctrl_pack_t;

  // Header carried with every instruction packet; payload width stays with the user.
  typedef struct packed {
    logic   valid;
    epoch_t tid;
  } insn_hdr_t;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/wired_fetch_queue_if.sv
// Packet-in / instructions-out bundle for the fetch queue.
interface wired_fetch_queue_if #(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH = 2,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned TID_W     = 1
);
  logic                            flush_i;
  logic [TID_W-1:0]                flush_tid_i;
  logic                            inp_valid_i;
  logic                            inp_ready_o;
  logic [IN_WIDTH-1:0]             inp_mask_i;
  logic [TID_W-1:0]                inp_tid_i;
  logic [IN_WIDTH*PAYLOAD_W-1:0]   inp_payload_i;
  logic                            oup_valid_o;
  logic                            oup_ready_i;
  logic [OUT_WIDTH-1:0]            oup_mask_o;
  logic [OUT_WIDTH*PAYLOAD_W-1:0]  oup_payload_o;
  logic [$clog2(DEPTH):0]          count_o;

  modport master (
    output flush_i, flush_tid_i, inp_valid_i, inp_mask_i, inp_tid_i, inp_payload_i, oup_ready_i,
    input  inp_ready_o, oup_valid_o, oup_mask_o, oup_payload_o, count_o
  );

  modport slave (
    input  flush_i, flush_tid_i, inp_valid_i, inp_mask_i, inp_tid_i, inp_payload_i, oup_ready_i,
    output inp_ready_o, oup_valid_o, oup_mask_o, oup_payload_o, count_o
  );
endinterface

// File: rtl/wired_lane_compact.sv
// Prefix popcount over a lane mask: per-lane write offset and total set-lane count.
module wired_lane_compact #(
  parameter int unsigned IN_WIDTH = 4,
  localparam int unsigned OffW    = $clog2(IN_WIDTH + 1)
) (
  input  logic [IN_WIDTH-1:0]           mask_i,
  output logic [IN_WIDTH-1:0][OffW-1:0] offset_o,
  output logic [OffW-1:0]               total_o
);

  always_comb begin : p_prefix
    logic [OffW-1:0] acc;
    acc = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      offset_o[i] = acc;
      acc         = acc + OffW'(mask_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/wired_fetch_queue.sv
// Compacting fetch queue: packs masked input lanes into a circular buffer, issues up to
// OUT_WIDTH oldest entries per cycle, and drops packets tagged with a stale redirect epoch.
module wired_fetch_queue
  import wired_fetch_queue_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 4,
  parameter int unsigned OUT_WIDTH = 2,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned TID_W     = 1
) (
  input logic                clk,
  input logic                rst_n,
  wired_fetch_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OffW = $clog2(IN_WIDTH + 1);

  logic [PAYLOAD_W-1:0] mem_q [DEPTH];

  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [TID_W-1:0] epoch_q, epoch_d;

  logic [IN_WIDTH-1:0][OffW-1:0] lane_off;
  logic [OffW-1:0]               lane_total;
  logic [IN_WIDTH-1:0][PtrW-1:0] widx;

  logic            inp_ready, accept, fresh, pop;
  logic [CntW-1:0] k_out, n_push, k_pop;

  wired_lane_compact #(
    .IN_WIDTH(IN_WIDTH)
  ) u_compact (
    .mask_i  (bus.inp_mask_i),
    .offset_o(lane_off),
    .total_o (lane_total)
  );

  // Ready looks only at registered occupancy, so a same-cycle pop never frees space early.
  assign inp_ready = (CntW'(DEPTH) - count_q) >= CntW'(IN_WIDTH);
  assign accept    = bus.inp_valid_i && inp_ready && !bus.flush_i;
  assign fresh     = accept && (bus.inp_tid_i == epoch_q);
  assign k_out     = CntW'(min_u(32'(count_q), OUT_WIDTH));
  assign pop       = (count_q != '0) && bus.oup_ready_i && !bus.flush_i;
  assign n_push    = fresh ? CntW'(lane_total) : '0;
  assign k_pop     = pop ? k_out : '0;

  always_comb begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      widx[i] = PtrW'(CntW'(tail_q) + CntW'(lane_off[i]));
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    epoch_d = epoch_q;
    if (bus.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      epoch_d = bus.flush_tid_i;
    end else begin
      head_d  = head_q + PtrW'(k_pop);
      tail_d  = tail_q + PtrW'(n_push);
      count_d = count_q + n_push - k_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      epoch_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      epoch_q <= epoch_d;
    end
  end

  // Storage is deliberately not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (rst_n && fresh) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (bus.inp_mask_i[i]) begin
          mem_q[widx[i]] <= bus.inp_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
  end

  always_comb begin
    bus.oup_mask_o    = '0;
    bus.oup_payload_o = '0;
    for (int j = 0; j < OUT_WIDTH; j++) begin
      bus.oup_mask_o[j]                        = CntW'(j) < k_out;
      bus.oup_payload_o[j*PAYLOAD_W +: PAYLOAD_W] = mem_q[head_q + PtrW'(j)];
    end
  end

  assign bus.inp_ready_o = inp_ready;
  assign bus.oup_valid_o = (count_q != '0);
  assign bus.count_o     = count_q;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CntW'(DEPTH));
  a_mask_contig: assert property (@(posedge clk) disable iff (!rst_n)
      ((bus.oup_mask_o + 1'b1) & bus.oup_mask_o) == '0);
  a_mask_le_cnt: assert property (@(posedge clk) disable iff (!rst_n)
      CntW'($countones(bus.oup_mask_o)) <= count_q);

endmodule

// File: tb/tb_wired_fetch_queue.sv
// Self-checking bench for wired_fetch_queue: vector table, directed corner sequences, and a
// randomized stream compared against a queue-based reference model.
module tb_wired_fetch_queue;

  localparam int unsigned IW = 4;
  localparam int unsigned OW = 2;
  localparam int unsigned D  = 8;
  localparam int unsigned PW = 16;
  localparam int unsigned TW = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wired_fetch_queue_if #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D), .PAYLOAD_W(PW), .TID_W(TW)
  ) bus ();

  wired_fetch_queue #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D), .PAYLOAD_W(PW), .TID_W(TW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic fl, input logic ft, input logic v, input logic [IW-1:0] m,
                       input logic t, input logic [IW*PW-1:0] p, input logic r);
    bus.flush_i       = fl;
    bus.flush_tid_i   = ft;
    bus.inp_valid_i   = v;
    bus.inp_mask_i    = m;
    bus.inp_tid_i     = t;
    bus.inp_payload_i = p;
    bus.oup_ready_i   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic [OW-1:0] om,
                           input logic irdy, input logic ovld);
    chk({tag, "_count"}, 64'(bus.count_o), 64'(cnt));
    chk({tag, "_omask"}, 64'(bus.oup_mask_o), 64'(om));
    chk({tag, "_irdy"}, 64'(bus.inp_ready_o), 64'(irdy));
    chk({tag, "_ovld"}, 64'(bus.oup_valid_o), 64'(ovld));
  endtask

  // Reference model: an ordered list of live payloads plus the current epoch.
  logic [PW-1:0] mq[$];
  logic          m_epoch;

  task automatic model_step(input logic fl, input logic ft, input logic v, input logic [IW-1:0] m,
                            input logic t, input logic [IW*PW-1:0] p, input logic r);
    int  sz;
    int  k;
    logic rdy;
    sz  = mq.size();
    rdy = (D - sz) >= IW;
    k   = (sz < OW) ? sz : OW;
    if (fl) begin
      mq.delete();
      m_epoch = ft;
    end else begin
      if (r && sz > 0) repeat (k) void'(mq.pop_front());
      if (v && rdy && t == m_epoch) begin
        for (int i = 0; i < IW; i++) if (m[i]) mq.push_back(p[i*PW +: PW]);
      end
    end
  endtask

  task automatic model_check(input string tag);
    int k;
    k = (mq.size() < OW) ? mq.size() : OW;
    chk({tag, "_count"}, 64'(bus.count_o), 64'(mq.size()));
    chk({tag, "_irdy"}, 64'(bus.inp_ready_o), 64'((D - mq.size()) >= IW));
    chk({tag, "_ovld"}, 64'(bus.oup_valid_o), 64'(mq.size() != 0));
    chk({tag, "_omask"}, 64'(bus.oup_mask_o), 64'((1 << k) - 1));
    for (int j = 0; j < OW; j++) begin
      if (j < k) chk({tag, "_lane"}, 64'(bus.oup_payload_o[j*PW +: PW]), 64'(mq[j]));
    end
  endtask

  typedef struct {
    logic          fl;
    logic          ft;
    logic          v;
    logic [IW-1:0] m;
    logic          t;
    logic          r;
    int            cnt;
    logic [OW-1:0] om;
    logic          irdy;
    logic          ovld;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [IW*PW-1:0] pay;
    logic [IW-1:0]    msk;
    logic             v, r, fl, ft, t;
    int               next_val;
    int               cyc;
    int               n;

    tbl[0]  = '{1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 4, 2'b11, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 8, 2'b11, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 6, 2'b11, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 4, 2'b11, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 2, 2'b11, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 0, 2'b00, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1, 2'b01, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 4, 2'b11, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 5, 2'b11, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 0, 2'b00, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 0, 2'b00, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 4'b0011, 1'b1, 1'b0, 2, 2'b11, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1, 0, 2'b00, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 4'b0011, 1'b1, 1'b0, 0, 2'b00, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 0, 2'b00, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1, 2'b01, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 4'b1011, 1'b0, 1'b1, 3, 2'b11, 1'b1, 1'b1};

    rst_n = 1'b0;
    bus.flush_i = 1'b0; bus.flush_tid_i = 1'b0; bus.inp_valid_i = 1'b0; bus.inp_mask_i = '0;
    bus.inp_tid_i = 1'b0; bus.inp_payload_i = '0; bus.oup_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 2'b00, 1'b1, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      pay = {4{16'(i)}};
      apply(tbl[i].fl, tbl[i].ft, tbl[i].v, tbl[i].m, tbl[i].t, pay, tbl[i].r);
      chk_state($sformatf("v%0d", i), tbl[i].cnt, tbl[i].om, tbl[i].irdy, tbl[i].ovld);
    end

    // Reset mid-stream must also return the epoch to 0.
    apply(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, '0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, 64'h1111_2222_3333_4444, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'b0011, 1'b1, 64'h5555_6666_7777_8888, 1'b0);
    chk_state("pre_rst", 6, 2'b11, 1'b0, 1'b1);
    rst_n = 1'b0;
    apply(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1, '0, 1'b1);
    chk_state("mid_rst", 0, 2'b00, 1'b1, 1'b0);
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, '0, 1'b0);
    chk("rst_epoch0_cnt", 64'(bus.count_o), 64'd2);
    apply(1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, '0, 1'b0);
    chk("rst_stale_cnt", 64'(bus.count_o), 64'd2);

    // Compaction order: lanes B and D of mask 1010 come out oldest-first.
    apply(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, '0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, 1'b0);
    chk_state("pack", 2, 2'b11, 1'b1, 1'b1);
    chk("pack_payload", 64'(bus.oup_payload_o), 64'h0000_0000_DDDD_BBBB);

    // Ordered stream of 0..23 with random masks and backpressure.
    apply(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, '0, 1'b0);
    mq.delete();
    m_epoch  = 1'b0;
    next_val = 0;
    cyc      = 0;
    while ((next_val < 24 || mq.size() != 0) && cyc < 600) begin
      model_check("stream");
      v   = (next_val < 24) && ($urandom_range(3) != 0);
      msk = 4'($urandom);
      if (24 - next_val < IW) msk = msk & 4'((1 << (24 - next_val)) - 1);
      r   = ($urandom_range(2) != 0);
      n   = 0;
      for (int i = 0; i < IW; i++) begin
        if (msk[i]) begin
          pay[i*PW +: PW] = 16'(next_val + n);
          n++;
        end else begin
          pay[i*PW +: PW] = 16'($urandom);
        end
      end
      if (v && (D - mq.size()) >= IW) next_val += n;
      model_step(1'b0, 1'b0, v, msk, 1'b0, pay, r);
      apply(1'b0, 1'b0, v, msk, 1'b0, pay, r);
      cyc++;
    end
    if (cyc >= 600) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout actual=%0d cycles required=<600", cyc);
    end
    model_check("stream_end");

    // Random epochs, flushes and backpressure.
    for (int c = 0; c < 400; c++) begin
      fl  = ($urandom_range(11) == 0);
      ft  = 1'($urandom);
      v   = ($urandom_range(3) != 0);
      msk = 4'($urandom);
      t   = ($urandom_range(3) == 0) ? ~m_epoch : m_epoch;
      r   = 1'($urandom);
      pay = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      model_step(fl, ft, v, msk, t, pay, r);
      apply(fl, ft, v, msk, t, pay, r);
      model_check("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
